// File: rtl/mem_wb_queue.sv
// Writeback queue between the LSU and the register-file writeback port.
// Circular FIFO with one slot held back for the result already in flight in the LSU.
module mem_wb_queue #(
   parameter int DEPTH  = 4,
   parameter int DATA_W = 64,
   parameter int SEQ_W  = 32,
   parameter int ALID_W = 7,
   parameter int PREG_W = 7
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   recoverFlag_i,
   input  logic                   wbValid_i,
   input  logic                   wbIsLoad_i,
   input  logic [SEQ_W-1:0]       wbSeqNo_i,
   input  logic [ALID_W-1:0]      wbAlID_i,
   input  logic [PREG_W-1:0]      wbPhyDest_i,
   input  logic [DATA_W-1:0]      wbData_i,
   input  logic                   wbReady_i,
   output logic                   wbValid_o,
   output logic                   wbIsLoad_o,
   output logic [SEQ_W-1:0]       wbSeqNo_o,
   output logic [ALID_W-1:0]      wbAlID_o,
   output logic [PREG_W-1:0]      wbPhyDest_o,
   output logic [DATA_W-1:0]      wbData_o,
   output logic                   stallIssue_o,
   output logic [$clog2(DEPTH):0] count_o,
   output logic                   overflow_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
   localparam logic [CNT_W-1:0] STALL_CNT = CNT_W'(DEPTH - 1);

   typedef struct packed {
      logic              is_load;
      logic [SEQ_W-1:0]  seq_no;
      logic [ALID_W-1:0] al_id;
      logic [PREG_W-1:0] phy_dest;
      logic [DATA_W-1:0] data;
   } entry_t;

   entry_t            mem_q [DEPTH];
   entry_t            wr_entry;
   entry_t            head_entry;

   logic [PTR_W-1:0]  head_q, head_d;
   logic [PTR_W-1:0]  tail_q, tail_d;
   logic [CNT_W-1:0]  count_q, count_d;
   logic              overflow_q, overflow_d;

   logic              full;
   logic              do_pop;
   logic              do_push;
   logic              do_drop;

   always_comb begin
      full    = (count_q == FULL_CNT);
      do_pop  = (count_q != '0) && wbReady_i;
      do_push = wbValid_i && !recoverFlag_i && (!full || do_pop);
      do_drop = wbValid_i && !recoverFlag_i && full && !do_pop;
   end

   // Store completions carry no register result, so their payload is zeroed on entry.
   always_comb begin
      wr_entry.is_load  = wbIsLoad_i;
      wr_entry.seq_no   = wbSeqNo_i;
      wr_entry.al_id    = wbAlID_i;
      wr_entry.phy_dest = wbIsLoad_i ? wbPhyDest_i : '0;
      wr_entry.data     = wbIsLoad_i ? wbData_i : '0;
   end

   always_comb begin
      head_d     = head_q;
      tail_d     = tail_q;
      count_d    = count_q;
      overflow_d = overflow_q;
      if (recoverFlag_i) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         if (do_push) begin
            tail_d = tail_q + PTR_W'(1);
         end
         if (do_pop) begin
            head_d = head_q + PTR_W'(1);
         end
         if (do_push && !do_pop) begin
            count_d = count_q + CNT_W'(1);
         end else if (do_pop && !do_push) begin
            count_d = count_q - CNT_W'(1);
         end
         if (do_drop) begin
            overflow_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         head_q     <= '0;
         tail_q     <= '0;
         count_q    <= '0;
         overflow_q <= 1'b0;
      end else begin
         head_q     <= head_d;
         tail_q     <= tail_d;
         count_q    <= count_d;
         overflow_q <= overflow_d;
      end
   end

   // Storage is never reset; validity comes only from count_q.
   always_ff @(posedge clk) begin
      if (do_push) begin
         mem_q[tail_q] <= wr_entry;
      end
   end

   always_comb begin
      head_entry = mem_q[head_q];
      wbValid_o  = (count_q != '0);
      if (wbValid_o) begin
         wbIsLoad_o  = head_entry.is_load;
         wbSeqNo_o   = head_entry.seq_no;
         wbAlID_o    = head_entry.al_id;
         wbPhyDest_o = head_entry.phy_dest;
         wbData_o    = head_entry.data;
      end else begin
         wbIsLoad_o  = 1'b0;
         wbSeqNo_o   = '0;
         wbAlID_o    = '0;
         wbPhyDest_o = '0;
         wbData_o    = '0;
      end
      stallIssue_o = (count_q >= STALL_CNT);
      count_o      = count_q;
      overflow_o   = overflow_q;
   end

endmodule

// File: tb/tb_mem_wb_queue.sv
// Scoreboard bench for mem_wb_queue: expected entries are queued on accepted pushes
// and compared against the head whenever a pop is taken.
module tb_mem_wb_queue;

   localparam int DEPTH = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        recoverFlag_i = 1'b0;
   logic        wbValid_i = 1'b0;
   logic        wbIsLoad_i = 1'b0;
   logic [31:0] wbSeqNo_i = '0;
   logic [6:0]  wbAlID_i = '0;
   logic [6:0]  wbPhyDest_i = '0;
   logic [63:0] wbData_i = '0;
   logic        wbReady_i = 1'b0;
   logic        wbValid_o;
   logic        wbIsLoad_o;
   logic [31:0] wbSeqNo_o;
   logic [6:0]  wbAlID_o;
   logic [6:0]  wbPhyDest_o;
   logic [63:0] wbData_o;
   logic        stallIssue_o;
   logic [2:0]  count_o;
   logic        overflow_o;

   typedef struct {
      logic        il;
      logic [31:0] seq;
      logic [6:0]  al;
      logic [6:0]  pd;
      logic [63:0] d;
   } exp_t;

   exp_t sb[$];
   int   m_count = 0;
   logic m_ovf = 1'b0;
   int   checks = 0;
   int   errors = 0;

   always #5 clk = ~clk;

   mem_wb_queue #(
      .DEPTH(DEPTH), .DATA_W(64), .SEQ_W(32), .ALID_W(7), .PREG_W(7)
   ) dut (
      .clk(clk), .reset(reset), .recoverFlag_i(recoverFlag_i),
      .wbValid_i(wbValid_i), .wbIsLoad_i(wbIsLoad_i), .wbSeqNo_i(wbSeqNo_i),
      .wbAlID_i(wbAlID_i), .wbPhyDest_i(wbPhyDest_i), .wbData_i(wbData_i),
      .wbReady_i(wbReady_i), .wbValid_o(wbValid_o), .wbIsLoad_o(wbIsLoad_o),
      .wbSeqNo_o(wbSeqNo_o), .wbAlID_o(wbAlID_o), .wbPhyDest_o(wbPhyDest_o),
      .wbData_o(wbData_o), .stallIssue_o(stallIssue_o), .count_o(count_o),
      .overflow_o(overflow_o)
   );

   // One clock cycle of stimulus; inputs change 1 time unit after the rising edge.
   task automatic step(input logic v, input logic il, input logic [31:0] seq,
                       input logic [6:0] al, input logic [6:0] pd, input logic [63:0] d,
                       input logic rdy, input logic rec, input logic rst);
      logic do_pop;
      logic do_push;
      exp_t e;
      exp_t n;
      wbValid_i = v; wbIsLoad_i = il; wbSeqNo_i = seq; wbAlID_i = al;
      wbPhyDest_i = pd; wbData_i = d; wbReady_i = rdy;
      recoverFlag_i = rec; reset = rst;
      do_pop  = rdy && (m_count != 0);
      do_push = v && !rec && ((m_count < DEPTH) || do_pop);
      if (!rst && do_pop) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL pop_scoreboard_empty: model count %0d but no expected entry", m_count);
         end else begin
            e = sb.pop_front();
            if ({wbIsLoad_o, wbSeqNo_o, wbAlID_o, wbPhyDest_o, wbData_o} !== {e.il, e.seq, e.al, e.pd, e.d}) begin
               errors++;
               $display("FAIL pop_head: got il=%0b seq=%0h al=%0h pd=%0h d=%0h expected il=%0b seq=%0h al=%0h pd=%0h d=%0h",
                        wbIsLoad_o, wbSeqNo_o, wbAlID_o, wbPhyDest_o, wbData_o, e.il, e.seq, e.al, e.pd, e.d);
            end
         end
      end
      if (rst) begin
         sb.delete(); m_count = 0; m_ovf = 1'b0;
      end else if (rec) begin
         sb.delete(); m_count = 0;
      end else begin
         if (v && (m_count == DEPTH) && !do_pop) m_ovf = 1'b1;
         if (do_push) begin
            n.il = il; n.seq = seq; n.al = al;
            n.pd = il ? pd : 7'd0;
            n.d  = il ? d : 64'd0;
            sb.push_back(n);
         end
         if (do_push && !do_pop) m_count++;
         else if (do_pop && !do_push) m_count--;
      end
      @(posedge clk); #1;
      checks++;
      if (count_o !== 3'(m_count)) begin
         errors++;
         $display("FAIL count: got %0d expected %0d", count_o, m_count);
      end
      checks++;
      if (wbValid_o !== (m_count != 0)) begin
         errors++;
         $display("FAIL valid: got %0b expected %0b", wbValid_o, (m_count != 0));
      end
      checks++;
      if (stallIssue_o !== (m_count >= DEPTH - 1)) begin
         errors++;
         $display("FAIL stall: got %0b expected %0b", stallIssue_o, (m_count >= DEPTH - 1));
      end
      checks++;
      if (overflow_o !== m_ovf) begin
         errors++;
         $display("FAIL overflow: got %0b expected %0b", overflow_o, m_ovf);
      end
   endtask

   task automatic idle();
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   task automatic push_load(input logic [31:0] seq, input logic [63:0] d);
      step(1, 1, seq, seq[6:0], 7'(seq + 1), d, 0, 0, 0);
   endtask

   task automatic drain();
      for (int i = 0; i < DEPTH + 1; i++) step(0, 0, 0, 0, 0, 0, 1, 0, 0);
   endtask

   task automatic test_reset();
      reset = 1'b1;
      @(posedge clk); #1;
      step(0, 0, 0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0, 0, 0);
      checks++;
      if ({wbValid_o, stallIssue_o, count_o} !== 5'b0) begin
         errors++;
         $display("FAIL reset_state: got valid=%0b stall=%0b count=%0d expected 0 0 0",
                  wbValid_o, stallIssue_o, count_o);
      end
      $display("test_reset: count=%0d valid=%0b", count_o, wbValid_o);
   endtask

   task automatic test_basic();
      step(1, 1, 32'd5, 7'd3, 7'd9, 64'hAB, 0, 0, 0);
      checks++;
      if ({wbValid_o, wbSeqNo_o, wbData_o, count_o} !== {1'b1, 32'd5, 64'hAB, 3'd1}) begin
         errors++;
         $display("FAIL basic_head: got valid=%0b seq=%0d data=%0h count=%0d expected 1 5 ab 1",
                  wbValid_o, wbSeqNo_o, wbData_o, count_o);
      end
      step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      checks++;
      if (count_o !== 3'd0) begin
         errors++;
         $display("FAIL basic_pop_count: got %0d expected 0", count_o);
      end
      $display("test_basic: seq 5 pushed and popped");
   endtask

   task automatic test_store();
      step(1, 0, 32'd77, 7'd4, 7'h12, 64'hFF, 0, 0, 0);
      checks++;
      if ({wbIsLoad_o, wbPhyDest_o, wbData_o} !== {1'b0, 7'd0, 64'd0}) begin
         errors++;
         $display("FAIL store_zero: got il=%0b pd=%0h d=%0h expected 0 0 0",
                  wbIsLoad_o, wbPhyDest_o, wbData_o);
      end
      drain();
      $display("test_store: store completion head pd=%0h d=%0h", wbPhyDest_o, wbData_o);
   endtask

   task automatic test_pushpop_full();
      for (int i = 0; i < DEPTH; i++) push_load(32'(10 + i), 64'(16'hA000 + i));
      for (int i = 0; i < 3; i++) begin
         step(1, 1, 32'(14 + i), 7'(14 + i), 7'(20 + i), 64'(16'hB000 + i), 1, 0, 0);
         checks++;
         if ({count_o, overflow_o} !== {3'd4, 1'b0}) begin
            errors++;
            $display("FAIL pushpop_full: got count=%0d ovf=%0b expected 4 0", count_o, overflow_o);
         end
      end
      drain();
      $display("test_pushpop_full: wrapped and drained, count=%0d", count_o);
   endtask

   task automatic test_recovery();
      for (int i = 0; i < 3; i++) push_load(32'(30 + i), 64'(30 + i));
      recoverFlag_i = 1'b1;
      #1;
      checks++;
      if (wbValid_o !== 1'b1) begin
         errors++;
         $display("FAIL recover_valid_during: got %0b expected 1", wbValid_o);
      end
      step(1, 1, 32'd99, 7'd1, 7'd2, 64'h99, 0, 1, 0);
      checks++;
      if ({count_o, wbValid_o, overflow_o} !== {3'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL recover_empty: got count=%0d valid=%0b ovf=%0b expected 0 0 0",
                  count_o, wbValid_o, overflow_o);
      end
      idle();
      $display("test_recovery: count=%0d after flush", count_o);
   endtask

   task automatic test_fill();
      for (int i = 1; i <= 3; i++) push_load(32'(i), 64'(i * 17));
      checks++;
      if ({stallIssue_o, count_o} !== {1'b1, 3'd3}) begin
         errors++;
         $display("FAIL fill_stall3: got stall=%0b count=%0d expected 1 3", stallIssue_o, count_o);
      end
      push_load(32'd4, 64'd68);
      checks++;
      if (count_o !== 3'd4) begin
         errors++;
         $display("FAIL fill_count4: got %0d expected 4", count_o);
      end
      push_load(32'd5, 64'd85);
      checks++;
      if ({count_o, overflow_o} !== {3'd4, 1'b1}) begin
         errors++;
         $display("FAIL fill_drop: got count=%0d ovf=%0b expected 4 1", count_o, overflow_o);
      end
      for (int i = 1; i <= 4; i++) begin
         checks++;
         if (wbSeqNo_o !== 32'(i)) begin
            errors++;
            $display("FAIL drain_order: got seq %0d expected %0d", wbSeqNo_o, i);
         end
         step(0, 0, 0, 0, 0, 0, 1, 0, 0);
      end
      $display("test_fill: drained, overflow=%0b", overflow_o);
   endtask

   task automatic test_reset_mid();
      push_load(32'd40, 64'd40);
      push_load(32'd41, 64'd41);
      step(1, 1, 32'd42, 7'd0, 7'd0, 64'd0, 1, 0, 1);
      checks++;
      if ({count_o, overflow_o, wbValid_o} !== {3'd0, 1'b0, 1'b0}) begin
         errors++;
         $display("FAIL reset_mid: got count=%0d ovf=%0b valid=%0b expected 0 0 0",
                  count_o, overflow_o, wbValid_o);
      end
      idle();
      $display("test_reset_mid: count=%0d ovf=%0b", count_o, overflow_o);
   endtask

   task automatic test_random();
      logic [31:0] seq;
      seq = 32'd1000;
      for (int i = 0; i < 300; i++) begin
         step(logic'($urandom_range(0, 1)), logic'($urandom_range(0, 1)), seq,
              7'($urandom), 7'($urandom), {$urandom, $urandom},
              ($urandom_range(0, 2) != 0), ($urandom_range(0, 39) == 0), 1'b0);
         seq++;
      end
      drain();
      $display("test_random: 300 cycles, leftover expected entries %0d", sb.size());
   endtask

   initial begin
      test_reset();
      test_basic();
      test_store();
      test_pushpop_full();
      test_recovery();
      test_fill();
      test_reset_mid();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
